param_write_arbiter: RTL and testbench

PARAM_WRITE_ARBITER -- requirements
Module: param_write_arbiter

---
 rtl/param_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_param_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_write_arbiter.sv
// Two-requester parameter write arbiter.
// Requester 0 is sysex and requester 1 is the preset loader. A granted write
// is latched and presented to the address decoder and the banks. It is then
// strobed with data_ready for HOLD_CYC cycles. After that the bus is left
// quiet for GAP_CYC cycles before the next grant.
//
// Handshake: reqN is a level request and is only looked at in IDLE. The
// matching ackN is a one-cycle pulse on the cycle after the grant edge; the
// requester may keep reqN high, and this is then treated as a fresh request
// at the next IDLE. bank_adr/param_adr/param_data are valid and stable from
// the ack cycle until the next ack, and data_ready marks the write window.
module param_write_arbiter #(
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 6,
  parameter int ADR_W    = 7
) (
  input  logic             CLOCK_25,
  input  logic             iRST,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       bank0,
  input  logic [2:0]       bank1,
  input  logic [ADR_W-1:0] adr0,
  input  logic [ADR_W-1:0] adr1,
  input  logic [7:0]       dat0,
  input  logic [7:0]       dat1,
  output logic             ack0,
  output logic             ack1,
  output logic             err,
  output logic [2:0]       bank_adr,
  output logic [ADR_W-1:0] param_adr,
  output logic [7:0]       param_data,
  output logic             data_ready,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_SETTLE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic [2:0]       bank_q, bank_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [7:0]       dat_q, dat_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err_q, err_d;
  logic             dr_q, dr_d;
  logic             busy_q, busy_d;

  logic             grant_any;
  logic             grant_side;
  logic [2:0]       grant_bank;
  logic             take;

  // Round-robin pick: the pointer only matters when both sides request.
  always_comb begin
    grant_any  = req0 | req1;
    grant_side = (req0 & req1) ? ptr_q : req1;
    grant_bank = grant_side ? bank1 : bank0;
  end

  // State register and all registered outputs; reset abandons any write.
  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 1'b0;
      bank_q  <= 3'd0;
      adr_q   <= '0;
      dat_q   <= 8'd0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      dr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      bank_q  <= bank_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      dr_q    <= dr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, then count through the strobe and settle phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    bank_d  = bank_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          take    = 1'b1;
          state_d = S_SETUP;
          ptr_d   = ~grant_side;
          bank_d  = grant_bank;
          adr_d   = grant_side ? adr1 : adr0;
          dat_d   = grant_side ? dat1 : dat0;
        end
      end
      S_SETUP: begin
        // Banks 5..7 do not exist: no strobe, just the settle gap.
        if (bank_q >= 3'd5) begin
          state_d = S_SETTLE;
          cnt_d   = 4'(GAP_CYC - 1);
        end else begin
          state_d = S_STROBE;
          cnt_d   = 4'(HOLD_CYC - 1);
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SETTLE;
          cnt_d   = 4'(GAP_CYC - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: outputs are computed from the next state so they register alongside it.
  always_comb begin
    ack0_d = take & ~grant_side;
    ack1_d = take & grant_side;
    err_d  = take & (grant_bank >= 3'd5);
    dr_d   = (state_d == S_STROBE);
    busy_d = (state_d != S_IDLE);
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err        = err_q;
  assign bank_adr   = bank_q;
  assign param_adr  = adr_q;
  assign param_data = dat_q;
  assign data_ready = dr_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_param_write_arbiter.sv
// Bench for param_write_arbiter: default-parameter instance driven by directed
// and random requests against a grant-timing model, plus a HOLD_CYC=4 /
// GAP_CYC=5 instance checked for strobe width and grant spacing.
module tb_param_write_arbiter;

  localparam int HOLD = 2;
  localparam int GAP  = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] bank0 = 3'd0, bank1 = 3'd0;
  logic [6:0] adr0 = 7'd0, adr1 = 7'd0;
  logic [7:0] dat0 = 8'd0, dat1 = 8'd0;
  logic       ack0, ack1, err, data_ready, busy;
  logic [2:0] bank_adr;
  logic [6:0] param_adr;
  logic [7:0] param_data;
  logic [1:0] state_dbg;

  param_write_arbiter #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .ADR_W(7)) dut (
    .CLOCK_25(clk), .iRST(rst),
    .req0(req0), .req1(req1), .bank0(bank0), .bank1(bank1),
    .adr0(adr0), .adr1(adr1), .dat0(dat0), .dat1(dat1),
    .ack0(ack0), .ack1(ack1), .err(err),
    .bank_adr(bank_adr), .param_adr(param_adr), .param_data(param_data),
    .data_ready(data_ready), .busy(busy), .state_dbg(state_dbg)
  );

  // Second instance with HOLD_CYC=4, GAP_CYC=5.
  logic       rst_b = 1'b1;
  logic       req0_b = 1'b0, req1_b = 1'b0;
  logic [2:0] bank_b = 3'd2;
  logic [6:0] adr_b = 7'h05;
  logic [7:0] dat_b = 8'h3C;
  logic       ack0_b, ack1_b, err_b, data_ready_b, busy_b;
  logic [2:0] bank_adr_b;
  logic [6:0] param_adr_b;
  logic [7:0] param_data_b;
  logic [1:0] state_dbg_b;

  param_write_arbiter #(.HOLD_CYC(4), .GAP_CYC(5), .ADR_W(7)) dut_b (
    .CLOCK_25(clk), .iRST(rst_b),
    .req0(req0_b), .req1(req1_b), .bank0(bank_b), .bank1(bank_b),
    .adr0(adr_b), .adr1(adr_b), .dat0(dat_b), .dat1(dat_b),
    .ack0(ack0_b), .ack1(ack1_b), .err(err_b),
    .bank_adr(bank_adr_b), .param_adr(param_adr_b), .param_data(param_data_b),
    .data_ready(data_ready_b), .busy(busy_b), .state_dbg(state_dbg_b)
  );

  // ---------------- counters / check helpers ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input int a, input int b);
    tests++;
    fails++;
    $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, a, b);
  endtask

  // ---------------- reference model ----------------
  // Expected entry: {ack_cyc[15:0], side, err, bank[2:0], adr[6:0], dat[7:0]}
  logic [35:0] exp_q[$];
  logic        m_ptr = 1'b0;
  int          m_free_at = 0;
  logic        g_valid = 1'b0;
  logic        g_side = 1'b0;

  // Edge e sees the currently driven inputs. A good write occupies
  // 2+HOLD+GAP edges and a bad-bank write 2+GAP edges before the next grant.
  task automatic model_step(input int e);
    logic       g;
    logic [2:0] b;
    logic       bad;
    g_valid = 1'b0;
    if (rst) begin
      m_ptr     = 1'b0;
      m_free_at = e + 1;
    end else if (e >= m_free_at && (req0 || req1)) begin
      g     = (req0 && req1) ? m_ptr : req1;
      m_ptr = !g;
      b     = g ? bank1 : bank0;
      bad   = (b >= 3'd5);
      exp_q.push_back({16'(e), g, bad, b, (g ? adr1 : adr0), (g ? dat1 : dat0)});
      m_free_at = e + (bad ? 2 + GAP : 2 + HOLD + GAP);
      g_valid = 1'b1;
      g_side  = g;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r0, input logic [2:0] b0, input logic [6:0] a0, input logic [7:0] d0,
                       input logic r1, input logic [2:0] b1, input logic [6:0] a1, input logic [7:0] d1,
                       input logic rs);
    @(negedge clk);
    rst = rs;
    req0 = r0; bank0 = b0; adr0 = a0; dat0 = d0;
    req1 = r1; bank1 = b1; adr1 = a1; dat1 = d1;
    model_step(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [2:0] rand_bank();
    if ($urandom_range(0, 5) == 0) return 3'($urandom_range(5, 7));
    return 3'($urandom_range(0, 4));
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic        r;
    logic        started;
    logic [35:0] e;
    logic [2:0]  eb;
    logic [6:0]  ea;
    logic [7:0]  ed;
    logic        cur_valid, cur_err;
    int          cur_ack;
    logic        exp_dr, exp_busy;
    started = 1'b0; cur_valid = 1'b0; cur_err = 1'b0; cur_ack = 0;
    eb = 0; ea = 0; ed = 0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        started = 1'b1; cur_valid = 1'b0; eb = 0; ea = 0; ed = 0;
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_err", err, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {bank_adr, param_adr, param_data}, 0);
      end else if (started) begin
        check("ack_exclusive", ack0 & ack1, 0);
        while (exp_q.size() > 0 && int'(exp_q[0][35:20]) < cyc) begin
          note_fail("missing_ack", 0, int'(exp_q[0][35:20]));
          void'(exp_q.pop_front());
        end
        if (ack0 || ack1) begin
          if (exp_q.size() == 0) begin
            note_fail("unexpected_ack", cyc, -1);
          end else if (int'(exp_q[0][35:20]) != cyc) begin
            note_fail("early_ack", cyc, int'(exp_q[0][35:20]));
          end else begin
            e = exp_q.pop_front();
            check("ack_side", {30'd0, ack1, ack0}, e[19] ? 2 : 1);
            check("ack_err", err, e[18]);
            eb = e[17:15]; ea = e[14:8]; ed = e[7:0];
            cur_valid = 1'b1; cur_err = e[18]; cur_ack = cyc;
          end
        end else begin
          check("err_without_ack", err, 0);
          if (exp_q.size() > 0 && int'(exp_q[0][35:20]) == cyc) begin
            note_fail("missing_ack", 0, cyc);
            void'(exp_q.pop_front());
          end
        end
        exp_dr   = cur_valid && !cur_err && cyc >= cur_ack + 1 && cyc <= cur_ack + HOLD;
        exp_busy = cur_valid && cyc <= cur_ack + (cur_err ? GAP : HOLD + GAP);
        check("data_ready", data_ready, exp_dr);
        check("busy", busy, exp_busy);
        check("bank_adr", bank_adr, eb);
        check("param_adr", param_adr, ea);
        check("param_data", param_data, ed);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       rr0, rr1, rrs;
    logic [2:0] rb0, rb1;
    logic [6:0] ra0, ra1;
    logic [7:0] rd0, rd1;
    int         a1, a2, w, k;
    logic       in_pulse, pulse_done;

    do_reset(3);

    // Single write to osc bank.
    drive(1, 3'd1, 7'h12, 8'hA5, 0, 0, 0, 0, 0);
    idle(12);

    // Contention from reset release: 0,1,0,1.
    do_reset(2);
    for (int i = 0; i < 40; i++) drive(1, 3'd0, 7'h01, 8'h11, 1, 3'd4, 7'h02, 8'h22, 0);
    idle(12);

    // Bad bank from requester 1.
    drive(0, 0, 0, 0, 1, 3'd6, 7'h33, 8'h44, 0);
    idle(10);

    // Reset during the first strobe cycle, then contention goes to requester 0.
    drive(1, 3'd2, 7'h55, 8'h66, 0, 0, 0, 0, 0);
    idle(1);
    do_reset(1);
    for (int i = 0; i < 3; i++) drive(1, 3'd3, 7'h0A, 8'h0B, 1, 3'd1, 7'h0C, 8'h0D, 0);
    idle(14);

    // Late request from requester 1 during settle of a requester-0 write.
    drive(1, 3'd3, 7'h21, 8'h43, 0, 0, 0, 0, 0);
    idle(6);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 3'd0, 7'h65, 8'h87, 0);
    idle(14);

    // Random traffic.
    rr0 = 0; rr1 = 0; rb0 = 0; rb1 = 0; ra0 = 0; ra1 = 0; rd0 = 0; rd1 = 0;
    for (int i = 0; i < 2500; i++) begin
      if (g_valid && !g_side && $urandom_range(0, 1) == 1) rr0 = 0;
      if (g_valid && g_side && $urandom_range(0, 1) == 1) rr1 = 0;
      if (!rr0 && $urandom_range(0, 3) == 0) begin
        rr0 = 1; rb0 = rand_bank(); ra0 = 7'($urandom); rd0 = 8'($urandom);
      end
      if (!rr1 && $urandom_range(0, 3) == 0) begin
        rr1 = 1; rb1 = rand_bank(); ra1 = 7'($urandom); rd1 = 8'($urandom);
      end
      rrs = ($urandom_range(0, 199) == 0);
      drive(rr0, rb0, ra0, rd0, rr1, rb1, ra1, rd1, rrs);
    end
    idle(20);
    check("exp_q_drained", exp_q.size(), 0);

    // HOLD_CYC=4 / GAP_CYC=5 instance: req0 held, strobe width and grant spacing.
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    req0_b = 1'b1;
    a1 = -1; a2 = -1; w = 0; in_pulse = 0; pulse_done = 0;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ack0_b) begin
        if (a1 < 0) a1 = k;
        else if (a2 < 0) a2 = k;
      end
      if (data_ready_b && !pulse_done) begin
        in_pulse = 1; w++;
      end else if (in_pulse) begin
        pulse_done = 1; in_pulse = 0;
      end
    end
    req0_b = 1'b0;
    check("b_first_ack_seen", a1 >= 0, 1);
    check("b_dr_width", w, 4);
    check("b_grant_spacing", a2 - a1, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
